unum4_div_frac: RTL and testbench
=================================

UNUM4_DIV_FRAC -- requirements
Module: unum4_div_frac

Interface
REQ-001 SHALL have parameter EXP_W, default 12, meaning signed exponent width of unpacked operands.
REQ-002 SHALL have parameter MAN_W, default 24, meaning mantissa width including the hidden bit, normalized to [2^(MAN_W-1), 2^MAN_W).
REQ-003 SHALL have these ports, clock and reset first:
  clk  input  1  sole clock, rising edge
  rst  input  1  reset, synchronous, active-high
  in_valid  input  1  operand pair valid
  in_ready  output  1  block accepts operands
  a_sign, b_sign  input  1 each  operand signs
  a_exp, b_exp  input  EXP_W each  signed exponents
  a_man, b_man  input  MAN_W each  mantissas (dividend a, divisor b)
  a_zero, b_zero  input  1 each  operand is zero
  a_nar, b_nar  input  1 each  operand is NaR
  out_valid  output  1  result valid
  out_ready  input  1  consumer accepts result
  res_sign  output  1  result sign
  res_exp  output  EXP_W+1  signed result exponent
  res_man  output  MAN_W  normalized quotient mantissa
  res_sticky  output  1  inexact: nonzero remainder or dropped quotient bit
  res_zero  output  1  result is zero
  res_nar  output  1  result is NaR

Function
REQ-004 SHALL instantiate unum4_div_subshift with DATA_W = 2*MAN_W+2, sign tied 0, dividend = a_man << MAN_W (zero-extended), divisor = b_man (zero-extended).
REQ-005 SHALL implement FSM states IDLE, RUN, NORM, OUT.
REQ-006 SHALL drive in_ready = 1 only in IDLE; transfer occurs on in_valid & in_ready at a rising edge, capturing all operand inputs into registers.
REQ-007 SHALL, on transfer with a_nar | b_nar | b_zero, go IDLE -> OUT with res_nar=1, res_zero=0, res_man=0, res_exp=0, res_sticky=0 (NaR has priority over zero).
REQ-008 SHALL, on transfer with a_zero (and no REQ-007 condition), go IDLE -> OUT with res_zero=1, res_nar=0, res_man=0, res_exp=0, res_sticky=0.
REQ-009 SHALL otherwise go IDLE -> RUN; divider en held 1 throughout RUN and 0 in every other state.
REQ-010 SHALL stay in RUN until divider done=1, then go to NORM, capturing quotient q and remainder r.
REQ-011 SHALL in NORM: if q[MAN_W]=1, res_man = q[MAN_W:1], res_exp = a_exp - b_exp, res_sticky = q[0] | (r != 0); else res_man = q[MAN_W-1:0], res_exp = a_exp - b_exp - 1, res_sticky = (r != 0); then go OUT.
REQ-012 SHALL compute res_exp with sign extension to EXP_W+1 bits; no saturation (overflow handling is downstream).
REQ-013 SHALL set res_sign = a_sign ^ b_sign for all results including zero and NaR.
REQ-014 SHALL assert out_valid only in OUT and hold all res_* stable while out_valid=1 and out_ready=0.
REQ-015 SHALL go OUT -> IDLE on out_ready=1, guaranteeing divider en low for at least one cycle between operations.
REQ-016 SHALL produce regular-path latency of one RUN entry cycle plus divider completion plus one NORM cycle; special-path result visible the cycle after transfer.
REQ-017 SHALL ignore in_valid and operand inputs outside IDLE.

Reset
REQ-018 SHALL, while rst=1 at a rising edge, enter IDLE, drive divider en 0, clear out_valid, res_sign, res_exp, res_man, res_sticky, res_zero, res_nar to 0; in_ready=1 the cycle after reset releases.
REQ-019 SHALL let rst abort any in-flight operation (RUN, NORM, OUT) with no result delivered.

Verification
REQ-020 MAN_W=24: a_man=0xC00000, b_man=0x800000, a_exp=3, b_exp=1 -> res_man=0xC00000, res_exp=2, res_sticky=0.
REQ-021 a_man=0x800000, b_man=0xC00000, exps 0,0 -> res_man=0xAAAAAA, res_exp=-1, res_sticky=1.
REQ-022 b_zero=1 with a_zero=1 -> res_nar=1, res_zero=0, out_valid the cycle after transfer, divider en never asserted.
REQ-023 a_zero=1, b_man=0x900000, a_sign=1, b_sign=0 -> res_zero=1, res_sign=1, res_man=0.
REQ-024 Result held with out_ready=0 for 10 cycles -> res_* unchanged, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-025 rst pulsed mid-RUN -> out_valid=0, outputs 0, in_ready=1 next cycle; next operation (REQ-020 values) completes correctly.

Source files
------------

// File: rtl/unum4_div_frac.sv
// Fraction divider for unpacked unum operands: restoring shift/subtract core plus
// a sequencing FSM that handles special operands, normalizes the quotient and holds the result.

module unum4_div_subshift #(
  parameter int DATA_W = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] r
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0] dvd_mag, dvs_mag;
  logic [DATA_W:0]   rem_sh, diff;

  always_comb begin
    dvd_mag   = (sign && dividend[DATA_W-1]) ? -dividend : dividend;
    dvs_mag   = (sign && divisor[DATA_W-1]) ? -divisor : divisor;
    rem_sh    = {rem_q, quo_q[DATA_W-1]};
    diff      = rem_sh - {1'b0, dvs_mag};
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (!en) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (!busy_q) begin
      busy_d    = 1'b1;
      cnt_d     = CNT_W'(DATA_W);
      quo_d     = dvd_mag;
      rem_d     = '0;
      neg_quo_d = sign & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      neg_rem_d = sign & dividend[DATA_W-1];
    end else if (cnt_q != '0) begin
      // One quotient bit per cycle; a borrow means the trial subtraction is rejected.
      cnt_d = cnt_q - 1'b1;
      quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
      rem_d = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign done = busy_q && (cnt_q == '0);
  assign q    = neg_quo_q ? -quo_q : quo_q;
  assign r    = neg_rem_q ? -rem_q : rem_q;
endmodule

// state | meaning
// IDLE  | ready for operands
// RUN   | divider enabled, waiting for done
// NORM  | normalize captured quotient, form exponent and sticky
// OUT   | result presented until out_ready
module unum4_div_frac #(
  parameter int EXP_W = 12,
  parameter int MAN_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] a_man,
  input  logic [MAN_W-1:0] b_man,
  input  logic             a_zero,
  input  logic             b_zero,
  input  logic             a_nar,
  input  logic             b_nar,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_sign,
  output logic [EXP_W:0]   res_exp,
  output logic [MAN_W-1:0] res_man,
  output logic             res_sticky,
  output logic             res_zero,
  output logic             res_nar
);
  localparam int DW = 2 * MAN_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, NORM, OUT} state_t;

  state_t           state_q, state_d;
  logic [EXP_W-1:0] a_exp_q, a_exp_d, b_exp_q, b_exp_d;
  logic [MAN_W-1:0] a_man_q, a_man_d, b_man_q, b_man_d;
  logic [MAN_W:0]   quo_q, quo_d;
  logic             rem_nz_q, rem_nz_d;
  logic             res_sign_q, res_sign_d;
  logic [EXP_W:0]   res_exp_q, res_exp_d;
  logic [MAN_W-1:0] res_man_q, res_man_d;
  logic             res_sticky_q, res_sticky_d;
  logic             res_zero_q, res_zero_d;
  logic             res_nar_q, res_nar_d;
  logic [EXP_W:0]   exp_diff;
  logic             div_en, div_done;
  logic [DW-1:0]    div_q, div_r;
  logic             unused_div_q;

  assign div_en       = (state_q == RUN);
  assign unused_div_q = ^div_q[DW-1:MAN_W+1];

  unum4_div_subshift #(.DATA_W(DW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (div_en),
    .sign     (1'b0),
    .dividend ({2'b00, a_man_q, {MAN_W{1'b0}}}),
    .divisor  ({{(MAN_W+2){1'b0}}, b_man_q}),
    .done     (div_done),
    .q        (div_q),
    .r        (div_r)
  );

  always_comb begin
    exp_diff     = {a_exp_q[EXP_W-1], a_exp_q} - {b_exp_q[EXP_W-1], b_exp_q};
    state_d      = state_q;
    a_exp_d      = a_exp_q;
    b_exp_d      = b_exp_q;
    a_man_d      = a_man_q;
    b_man_d      = b_man_q;
    quo_d        = quo_q;
    rem_nz_d     = rem_nz_q;
    res_sign_d   = res_sign_q;
    res_exp_d    = res_exp_q;
    res_man_d    = res_man_q;
    res_sticky_d = res_sticky_q;
    res_zero_d   = res_zero_q;
    res_nar_d    = res_nar_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_exp_d    = a_exp;
        b_exp_d    = b_exp;
        a_man_d    = a_man;
        b_man_d    = b_man;
        res_sign_d = a_sign ^ b_sign;
        if (a_nar || b_nar || b_zero || a_zero) begin
          res_nar_d    = a_nar || b_nar || b_zero;
          res_zero_d   = !(a_nar || b_nar || b_zero);
          res_man_d    = '0;
          res_exp_d    = '0;
          res_sticky_d = 1'b0;
          state_d      = OUT;
        end else begin
          state_d = RUN;
        end
      end
      RUN: if (div_done) begin
        quo_d    = div_q[MAN_W:0];
        rem_nz_d = |div_r;
        state_d  = NORM;
      end
      NORM: begin
        res_zero_d = 1'b0;
        res_nar_d  = 1'b0;
        if (quo_q[MAN_W]) begin
          res_man_d    = quo_q[MAN_W:1];
          res_exp_d    = exp_diff;
          res_sticky_d = quo_q[0] | rem_nz_q;
        end else begin
          res_man_d    = quo_q[MAN_W-1:0];
          res_exp_d    = exp_diff - 1'b1;
          res_sticky_d = rem_nz_q;
        end
        state_d = OUT;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_exp_q      <= '0;
      b_exp_q      <= '0;
      a_man_q      <= '0;
      b_man_q      <= '0;
      quo_q        <= '0;
      rem_nz_q     <= 1'b0;
      res_sign_q   <= 1'b0;
      res_exp_q    <= '0;
      res_man_q    <= '0;
      res_sticky_q <= 1'b0;
      res_zero_q   <= 1'b0;
      res_nar_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_exp_q      <= a_exp_d;
      b_exp_q      <= b_exp_d;
      a_man_q      <= a_man_d;
      b_man_q      <= b_man_d;
      quo_q        <= quo_d;
      rem_nz_q     <= rem_nz_d;
      res_sign_q   <= res_sign_d;
      res_exp_q    <= res_exp_d;
      res_man_q    <= res_man_d;
      res_sticky_q <= res_sticky_d;
      res_zero_q   <= res_zero_d;
      res_nar_q    <= res_nar_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == OUT);
  assign res_sign   = res_sign_q;
  assign res_exp    = res_exp_q;
  assign res_man    = res_man_q;
  assign res_sticky = res_sticky_q;
  assign res_zero   = res_zero_q;
  assign res_nar    = res_nar_q;
endmodule

// File: tb/tb_unum4_div_frac.sv
// Scoreboard bench for unum4_div_frac: expected results are queued at operand transfer
// and a negedge monitor compares them on each output handshake.

module tb_unum4_div_frac;
  localparam int EW = 12;
  localparam int MW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic          a_sign, b_sign;
  logic [EW-1:0] a_exp, b_exp;
  logic [MW-1:0] a_man, b_man;
  logic          a_zero, b_zero, a_nar, b_nar;
  logic          out_valid, out_ready;
  logic          res_sign;
  logic [EW:0]   res_exp;
  logic [MW-1:0] res_man;
  logic          res_sticky, res_zero, res_nar;

  typedef struct {
    logic          sign;
    logic [EW:0]   exp;
    logic [MW-1:0] man;
    logic          sticky;
    logic          zero;
    logic          nar;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   en_cnt = 0;
  bit   rand_ready = 0;
  bit   force_ready = 1;

  unum4_div_frac #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
    .a_man(a_man), .b_man(b_man), .a_zero(a_zero), .b_zero(b_zero),
    .a_nar(a_nar), .b_nar(b_nar), .out_valid(out_valid), .out_ready(out_ready),
    .res_sign(res_sign), .res_exp(res_exp), .res_man(res_man),
    .res_sticky(res_sticky), .res_zero(res_zero), .res_nar(res_nar)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired, got timeout expected completion", name);
  endtask

  // Reference: quotient of real-valued mantissas scaled to MW bits, normalized into [2^(MW-1), 2^MW).
  function automatic exp_t model(input bit as, input int ae, input logic [MW-1:0] am, input bit az,
                                 input bit an, input bit bs, input int be, input logic [MW-1:0] bm,
                                 input bit bz, input bit bn);
    exp_t e;
    longint unsigned num, quo, rem;
    int x;
    e.sign = as ^ bs; e.exp = '0; e.man = '0; e.sticky = 0; e.zero = 0; e.nar = 0;
    if (an || bn || bz) e.nar = 1;
    else if (az) e.zero = 1;
    else begin
      num = longint'(am) * (64'd1 << MW);
      quo = num / longint'(bm);
      rem = num % longint'(bm);
      if (quo >= (64'd1 << MW)) begin
        e.man = MW'(quo / 2);
        x = ae - be;
        e.sticky = (quo % 2 != 0) || (rem != 0);
      end else begin
        e.man = MW'(quo);
        x = ae - be - 1;
        e.sticky = (rem != 0);
      end
      e.exp = x[EW:0];
    end
    return e;
  endfunction

  task automatic issue(input bit as, input int ae, input logic [MW-1:0] am, input bit az,
                       input bit an, input bit bs, input int be, input logic [MW-1:0] bm,
                       input bit bz, input bit bn);
    bit got = 0;
    a_sign = as; a_exp = ae[EW-1:0]; a_man = am; a_zero = az; a_nar = an;
    b_sign = bs; b_exp = be[EW-1:0]; b_man = bm; b_zero = bz; b_nar = bn;
    in_valid = 1;
    for (int i = 0; i < 500; i++) begin
      bit r;
      r = in_ready;
      @(posedge clk);
      if (r) begin
        sb.push_back(model(as, ae, am, az, an, bs, be, bm, bz, bn));
        got = 1;
      end
      #1;
      if (got) break;
    end
    in_valid = 0;
    if (!got) fail_now("issue_accept");
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
  endtask

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    end
  end

  always @(posedge clk) if (dut.div_en) en_cnt++;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_output: got res_man %0h expected no output", res_man);
      end else begin
        mon_e = sb.pop_front();
        check("res_sign", 64'(res_sign), 64'(mon_e.sign));
        check("res_exp", 64'(res_exp), 64'(mon_e.exp));
        check("res_man", 64'(res_man), 64'(mon_e.man));
        check("res_sticky", 64'(res_sticky), 64'(mon_e.sticky));
        check("res_zero", 64'(res_zero), 64'(mon_e.zero));
        check("res_nar", 64'(res_nar), 64'(mon_e.nar));
      end
    end
  end

  initial begin
    int en0;
    rst = 1; in_valid = 0;
    a_sign = 0; b_sign = 0; a_exp = '0; b_exp = '0; a_man = '0; b_man = '0;
    a_zero = 0; b_zero = 0; a_nar = 0; b_nar = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({out_valid, res_sign, res_exp, res_man, res_sticky, res_zero, res_nar}), 64'd0);
    rst = 0;
    @(posedge clk); #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    issue(0, 3, 24'hC00000, 0, 0, 0, 1, 24'h800000, 0, 0);
    issue(0, 0, 24'h800000, 0, 0, 0, 0, 24'hC00000, 0, 0);
    drain();

    en0 = en_cnt;
    issue(0, 5, 24'h900000, 1, 0, 1, 2, 24'hA00000, 1, 0);
    check("special_latency", 64'(out_valid), 64'd1);
    drain();
    check("special_no_en", 64'(en_cnt - en0), 64'd0);

    issue(1, 7, 24'hABCDEF, 1, 0, 0, 4, 24'h900000, 0, 0);
    issue(1, -2048, 24'hFFFFFF, 0, 0, 0, 2047, 24'h800000, 0, 0);
    issue(0, 2047, 24'h800000, 0, 0, 1, -2048, 24'hFFFFFF, 0, 0);
    drain();

    // Back-pressure: result must hold and new operands must be ignored.
    force_ready = 0;
    issue(0, 3, 24'hC00000, 0, 0, 0, 1, 24'h800000, 0, 0);
    for (int i = 0; i < 200 && !out_valid; i++) begin @(posedge clk); #1; end
    if (!out_valid) fail_now("hold_wait_valid");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; a_nar = 1; a_man = 24'h812345;
      @(posedge clk); #1;
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out", 64'({out_valid, res_man, res_exp, res_sticky, res_nar}),
            64'({1'b1, 24'hC00000, 13'd2, 1'b0, 1'b0}));
    end
    in_valid = 0; a_nar = 0;
    force_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_release", 64'({in_ready, out_valid}), 64'(2'b10));
    drain();

    // Reset mid-RUN aborts the operation.
    issue(0, 0, 24'h800000, 0, 0, 0, 0, 24'hC00000, 0, 0);
    repeat (5) @(posedge clk);
    #1; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    sb.delete();
    check("abort_outputs", 64'({out_valid, res_sign, res_exp, res_man, res_sticky, res_zero, res_nar}), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    issue(0, 3, 24'hC00000, 0, 0, 0, 1, 24'h800000, 0, 0);
    drain();

    rand_ready = 1;
    for (int n = 0; n < 60; n++) begin
      int ae, be;
      logic [MW-1:0] am, bm;
      ae = int'($urandom_range(0, 4095)) - 2048;
      be = int'($urandom_range(0, 4095)) - 2048;
      am = 24'h800000 | MW'($urandom_range(0, 24'h7FFFFF));
      bm = 24'h800000 | MW'($urandom_range(0, 24'h7FFFFF));
      if (n % 7 == 0) bm = am;
      issue($urandom_range(0, 1) == 1, ae, am, $urandom_range(0, 9) == 0,
            $urandom_range(0, 14) == 0, $urandom_range(0, 1) == 1, be, bm,
            $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
